// File: rtl/reg_file_wb.sv
// reg_file_wb: 128 x 128-bit SPU register file with even/odd writeback ports,
// three registered read ports with same-cycle writeback bypass, and a
// combinational stall request for sources still in delay stages 0-1.
module reg_file_wb #(
    parameter  int unsigned WIDTH = 128,
    parameter  int unsigned REGS  = 128,
    localparam int unsigned AW    = 7
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [0:AW-1]          ra_addr,
    input  logic [0:AW-1]          rb_addr,
    input  logic [0:AW-1]          rc_addr,
    input  logic                   ra_used,
    input  logic                   rb_used,
    input  logic                   rc_used,
    input  logic                   rd_en,
    input  logic [0:WIDTH-1]       rt_wb_even,
    input  logic [0:WIDTH-1]       rt_wb_odd,
    input  logic [0:AW-1]          rt_addr_wb_even,
    input  logic [0:AW-1]          rt_addr_wb_odd,
    input  logic                   reg_write_wb_even,
    input  logic                   reg_write_wb_odd,
    input  logic [3:0][0:AW-1]     rt_addr_delay_even,
    input  logic [3:0][0:AW-1]     rt_addr_delay_odd,
    input  logic [3:0]             reg_write_delay_even,
    input  logic [3:0]             reg_write_delay_odd,
    output logic [0:WIDTH-1]       ra,
    output logic [0:WIDTH-1]       rb,
    output logic [0:WIDTH-1]       rc,
    output logic                   stall,
    output logic                   wr_conflict
);

    logic [0:WIDTH-1] mem [REGS];
    logic [0:WIDTH-1] ra_nxt, rb_nxt, rc_nxt;
    logic             same_addr_wr;

    // Stages 2 and 3 are covered by bypass / already in the file.
    logic unused_late_stages;
    assign unused_late_stages = ^{rt_addr_delay_even[3:2], rt_addr_delay_odd[3:2],
                                  reg_write_delay_even[3:2], reg_write_delay_odd[3:2]};

    assign same_addr_wr = reg_write_wb_even && reg_write_wb_odd &&
                          (rt_addr_wb_even == rt_addr_wb_odd);

    // Read-port values with writeback bypass; odd wins over even.
    always_comb begin
        ra_nxt = mem[ra_addr];
        rb_nxt = mem[rb_addr];
        rc_nxt = mem[rc_addr];
        if (reg_write_wb_even && rt_addr_wb_even == ra_addr) ra_nxt = rt_wb_even;
        if (reg_write_wb_even && rt_addr_wb_even == rb_addr) rb_nxt = rt_wb_even;
        if (reg_write_wb_even && rt_addr_wb_even == rc_addr) rc_nxt = rt_wb_even;
        if (reg_write_wb_odd  && rt_addr_wb_odd  == ra_addr) ra_nxt = rt_wb_odd;
        if (reg_write_wb_odd  && rt_addr_wb_odd  == rb_addr) rb_nxt = rt_wb_odd;
        if (reg_write_wb_odd  && rt_addr_wb_odd  == rc_addr) rc_nxt = rt_wb_odd;
    end

    // Register array writes; odd written last so it wins on a same-address conflict.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(REGS); i++) mem[i] <= '0;
        end else begin
            if (reg_write_wb_even) mem[rt_addr_wb_even] <= rt_wb_even;
            if (reg_write_wb_odd)  mem[rt_addr_wb_odd]  <= rt_wb_odd;
        end
    end

    // Registered read ports, held while rd_en is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ra <= '0;
            rb <= '0;
            rc <= '0;
        end else if (rd_en) begin
            ra <= ra_nxt;
            rb <= rb_nxt;
            rc <= rc_nxt;
        end
    end

    // Sticky flag for both pipes writing one address in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)            wr_conflict <= 1'b0;
        else if (same_addr_wr) wr_conflict <= 1'b1;
    end

    // Hazard: a consumed source matches an enabled destination in delay stage 0 or 1.
    always_comb begin
        stall = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (reg_write_delay_even[k]) begin
                if (ra_used && ra_addr == rt_addr_delay_even[k]) stall = 1'b1;
                if (rb_used && rb_addr == rt_addr_delay_even[k]) stall = 1'b1;
                if (rc_used && rc_addr == rt_addr_delay_even[k]) stall = 1'b1;
            end
            if (reg_write_delay_odd[k]) begin
                if (ra_used && ra_addr == rt_addr_delay_odd[k]) stall = 1'b1;
                if (rb_used && rb_addr == rt_addr_delay_odd[k]) stall = 1'b1;
                if (rc_used && rc_addr == rt_addr_delay_odd[k]) stall = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed self-checking bench for reg_file_wb.
module tb_reg_file_wb;

    logic             clk = 1'b0;
    logic             reset;
    logic [0:6]       ra_addr, rb_addr, rc_addr;
    logic             ra_used, rb_used, rc_used, rd_en;
    logic [0:127]     rt_wb_even, rt_wb_odd;
    logic [0:6]       rt_addr_wb_even, rt_addr_wb_odd;
    logic             reg_write_wb_even, reg_write_wb_odd;
    logic [3:0][0:6]  rt_addr_delay_even, rt_addr_delay_odd;
    logic [3:0]       reg_write_delay_even, reg_write_delay_odd;
    logic [0:127]     ra, rb, rc;
    logic             stall, wr_conflict;

    int checks   = 0;
    int failures = 0;

    localparam logic [0:127] C1   = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [0:127] C2   = 128'hDEADBEEF00000000CAFEF00D12345678;
    localparam logic [0:127] C3   = 128'h5555555555555555AAAAAAAAAAAAAAAA;
    localparam logic [0:127] AAS  = {16{8'hAA}};
    localparam logic [0:127] ONES = {128{1'b1}};

    reg_file_wb dut (
        .clk(clk), .reset(reset),
        .ra_addr(ra_addr), .rb_addr(rb_addr), .rc_addr(rc_addr),
        .ra_used(ra_used), .rb_used(rb_used), .rc_used(rc_used),
        .rd_en(rd_en),
        .rt_wb_even(rt_wb_even), .rt_wb_odd(rt_wb_odd),
        .rt_addr_wb_even(rt_addr_wb_even), .rt_addr_wb_odd(rt_addr_wb_odd),
        .reg_write_wb_even(reg_write_wb_even), .reg_write_wb_odd(reg_write_wb_odd),
        .rt_addr_delay_even(rt_addr_delay_even), .rt_addr_delay_odd(rt_addr_delay_odd),
        .reg_write_delay_even(reg_write_delay_even), .reg_write_delay_odd(reg_write_delay_odd),
        .ra(ra), .rb(rb), .rc(rc), .stall(stall), .wr_conflict(wr_conflict)
    );

    always #5 clk = ~clk;

    task automatic chk128(input string tag, input logic [0:127] obs, input logic [0:127] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic no_wr();
        reg_write_wb_even = 1'b0;
        reg_write_wb_odd  = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        ra_addr = '0; rb_addr = '0; rc_addr = '0;
        ra_used = 1'b0; rb_used = 1'b0; rc_used = 1'b0; rd_en = 1'b0;
        rt_wb_even = '0; rt_wb_odd = '0;
        rt_addr_wb_even = '0; rt_addr_wb_odd = '0;
        reg_write_wb_even = 1'b0; reg_write_wb_odd = 1'b0;
        rt_addr_delay_even = '0; rt_addr_delay_odd = '0;
        reg_write_delay_even = '0; reg_write_delay_odd = '0;

        tick(); tick();
        #3 reset = 1'b1;

        // Read after reset
        ra_addr = 7'd5; rb_addr = 7'd6; rc_addr = 7'd7; rd_en = 1'b1;
        tick();
        chk128("reset_ra", ra, '0);
        chk128("reset_rb", rb, '0);
        chk128("reset_rc", rc, '0);
        chk1("reset_conflict", wr_conflict, 1'b0);

        // Even write r10, then read r10/r11
        rd_en = 1'b0;
        reg_write_wb_even = 1'b1; rt_addr_wb_even = 7'd10; rt_wb_even = C1;
        tick();
        no_wr();
        ra_addr = 7'd10; rb_addr = 7'd11; rd_en = 1'b1;
        tick();
        chk128("rd_r10", ra, C1);
        chk128("rd_r11", rb, '0);

        // rd_en low holds outputs
        rd_en = 1'b0; ra_addr = 7'd20; rb_addr = 7'd21;
        tick();
        chk128("hold_ra", ra, C1);

        // Odd r20 bypass, even r50 bypass, both land
        reg_write_wb_odd  = 1'b1; rt_addr_wb_odd  = 7'd20; rt_wb_odd  = AAS;
        reg_write_wb_even = 1'b1; rt_addr_wb_even = 7'd50; rt_wb_even = C2;
        ra_addr = 7'd20; rb_addr = 7'd10; rc_addr = 7'd50; rd_en = 1'b1;
        tick();
        chk128("byp_odd_ra", ra, AAS);
        chk128("file_rb", rb, C1);
        chk128("byp_even_rc", rc, C2);
        no_wr();
        ra_addr = 7'd50; rb_addr = 7'd20;
        tick();
        chk128("dual_r50", ra, C2);
        chk128("dual_r20", rb, AAS);

        // Same-address conflict: odd wins, sticky flag
        reg_write_wb_even = 1'b1; rt_addr_wb_even = 7'd30; rt_wb_even = 128'd1;
        reg_write_wb_odd  = 1'b1; rt_addr_wb_odd  = 7'd30; rt_wb_odd  = 128'd2;
        ra_addr = 7'd30;
        tick();
        chk128("conf_byp", ra, 128'd2);
        chk1("conf_flag", wr_conflict, 1'b1);
        no_wr();
        reg_write_wb_even = 1'b1; rt_addr_wb_even = 7'd31; rt_wb_even = 128'd5;
        rb_addr = 7'd31;
        tick();
        chk128("conf_file", ra, 128'd2);
        chk128("clean_byp_r31", rb, 128'd5);
        chk1("conf_sticky", wr_conflict, 1'b1);
        no_wr();

        // Register 0 is writable
        rd_en = 1'b0;
        reg_write_wb_odd = 1'b1; rt_addr_wb_odd = 7'd0; rt_wb_odd = C3;
        tick();
        no_wr();
        ra_addr = 7'd0; rd_en = 1'b1;
        tick();
        chk128("r0_write", ra, C3);
        rd_en = 1'b0;

        // Hazard detection
        ra_addr = 7'd12; ra_used = 1'b1;
        rt_addr_delay_odd[1] = 7'd12; reg_write_delay_odd[1] = 1'b1;
        #1 chk1("stall_odd1", stall, 1'b1);
        ra_used = 1'b0;
        #1 chk1("stall_unused", stall, 1'b0);
        ra_used = 1'b1;
        rt_addr_delay_odd[1] = 7'd99;
        rt_addr_delay_odd[2] = 7'd12; reg_write_delay_odd[2] = 1'b1;
        rt_addr_delay_even[3] = 7'd12; reg_write_delay_even[3] = 1'b1;
        #1 chk1("stall_stage23", stall, 1'b0);
        rt_addr_delay_odd[1] = 7'd12; reg_write_delay_odd[1] = 1'b0;
        #1 chk1("stall_en_low", stall, 1'b0);
        rc_addr = 7'd77; rc_used = 1'b1;
        rt_addr_delay_even[0] = 7'd77; reg_write_delay_even[0] = 1'b1;
        #1 chk1("stall_even0_rc", stall, 1'b1);
        rc_used = 1'b0;
        #1 chk1("stall_rc_unused", stall, 1'b0);
        ra_used = 1'b0;
        reg_write_delay_even = '0; reg_write_delay_odd = '0;

        // Reset mid-operation
        reg_write_wb_even = 1'b1; rt_addr_wb_even = 7'd40; rt_wb_even = ONES;
        tick();
        no_wr();
        ra_addr = 7'd40; rd_en = 1'b1;
        tick();
        chk128("pre_reset_r40", ra, ONES);
        #3 reset = 1'b0;
        #1;
        chk128("async_ra", ra, '0);
        chk1("async_conflict", wr_conflict, 1'b0);
        reg_write_wb_odd = 1'b1; rt_addr_wb_odd = 7'd41; rt_wb_odd = C2;
        tick();
        no_wr();
        #3 reset = 1'b1;
        ra_addr = 7'd40; rb_addr = 7'd41; rc_addr = 7'd30;
        tick();
        chk128("post_reset_r40", ra, '0);
        chk128("post_reset_r41", rb, '0);
        chk128("post_reset_r30", rc, '0);
        chk1("post_reset_conflict", wr_conflict, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
